network_transmit_serializer: RTL and testbench
==============================================

NETWORK_TRANSMIT_SERIALIZER -- requirements
Module: network_transmit_serializer

Interface
REQ-001 The block SHALL have one clock and one reset: reset is asynchronous and active-high.
REQ-002 Ports SHALL be: clk_sys in 1, system and GMII TX clock; reset in 1, async active-high reset; i_pkt_wr in 1, word valid; iv_pkt in 134, packet word; o_pkt_ready out 1, holding register empty; o_gmii_tx_en out 1; ov_gmii_txd out 8; o_gmii_tx_er out 1; o_outpkt_pulse out 1, frame completed; o_discard_pkt_pulse out 1, orphan word dropped; o_fifo_underflow_pulse out 1, frame aborted; ov_tx_state out 3, FSM state.
REQ-003 Word format SHALL be: [133:132] 01 head, 10 tail, 11 head+tail, 00 middle; [131:128] invalid byte count of a tail word (0 = all 16 valid); [127:0] data, first byte [127:120].
REQ-004 Parameter IFG_CYCLES SHALL default to 12: the minimum number of idle cycles between frames.

Function
REQ-005 A word SHALL be accepted only when i_pkt_wr and o_pkt_ready are both 1; writes while o_pkt_ready=0 SHALL be ignored.
REQ-006 o_pkt_ready SHALL equal NOT(holding valid), so the holding register is one word deep.
REQ-007 FSM states SHALL be IDLE=0, PRE=1, DATA=2, IFG=3 and DISCARD=4, and ov_tx_state SHALL show the current state.
REQ-008 In IDLE, a holding word without the head flag SHALL be dropped, with a one-cycle o_discard_pkt_pulse.
REQ-009 In IDLE, a head word SHALL move the FSM to PRE, and that word SHALL move into the shift register.
REQ-010 If the head word is accepted in cycle t, the first preamble byte SHALL appear on the outputs in cycle t+2.
REQ-011 In PRE, outputs SHALL be tx_en=1 for 8 cycles: txd=0x55 for 7 cycles, then 0xD5.
REQ-012 In DATA, the block SHALL output one byte per cycle with tx_en=1, MSB byte first, covering 16 bytes per word or 16 minus invalid for a tail word.
REQ-013 At the last byte of a non-tail word, a word in the holding register SHALL load into the shift register in the same cycle, with no gap on txd.
REQ-014 At the last byte of a non-tail word with the holding register empty (underflow), the next cycle SHALL drive tx_en=1, tx_er=1 and txd=0, and SHALL pulse o_fifo_underflow_pulse; the FSM SHALL then enter DISCARD.
REQ-015 A head-flagged word arriving as a continuation word SHALL be treated as an underflow.
REQ-016 DISCARD SHALL accept and drop words until a tail word arrives, then enter IFG.
REQ-017 After the last byte of a tail word, the block SHALL pulse o_outpkt_pulse for one cycle and enter IFG.
REQ-018 IFG SHALL hold tx_en=0 for exactly IFG_CYCLES cycles, then enter IDLE.
REQ-019 A head word that arrives during IFG SHALL be held and SHALL start PRE on the first cycle after IDLE is reached.
REQ-020 The FCS SHALL arrive in the words from upstream and SHALL NOT be generated, checked or padded by this block.
REQ-021 All GMII outputs and pulses SHALL be registered.

Reset
REQ-022 Reset SHALL set tx_en=0, tx_er=0, txd=0x00, all pulses=0, o_pkt_ready=1, state=IDLE, holding valid=0, and byte counter=0.
REQ-023 Reset asserted mid-frame SHALL truncate the frame immediately with no tx_er; after release, words SHALL be treated per REQ-008.

Structure
REQ-024 Package network_tx_pkg SHALL hold the state encoding, the flag encodings, the constants PREAMBLE_BYTE=0x55 and SFD_BYTE=0xD5, and the IFG_CYCLES default.
REQ-025 One sub-module SHALL exist: gmii_byte_shifter, which holds the 128-bit shift register, the byte index and the last-byte detection.

Verification
REQ-026 64-byte frame (4 words, tail invalid=0, written back-to-back as ready allows) -> tx_en high for 72 cycles (8 preamble/SFD + 64 data), txd order matches the data, one o_outpkt_pulse.
REQ-027 65-byte frame (5 words, tail invalid=15) -> 73 tx_en cycles, with the last data byte equal to [127:120] of the tail word.
REQ-028 Two 64-byte frames offered continuously -> exactly 12 tx_en=0 cycles between the two SFD-delimited frames.
REQ-029 Third word of a frame delayed by 20 cycles -> after byte 32, one cycle with tx_en=1 and tx_er=1, one underflow pulse, remaining words dropped through the tail, then 12-cycle IFG.
REQ-030 Middle word (flags 00) written while IDLE -> o_discard_pkt_pulse=1 for one cycle, tx_en stays 0.
REQ-031 Reset asserted at data byte 10 -> tx_en=0 in the same cycle as reset, state=0, o_pkt_ready=1.

Source files
------------

// File: rtl/network_transmit_serializer_pkg.sv
// Shared types and constants for the GMII transmit serializer.
// Word layout: [133:132] flags, [131:128] tail invalid count, [127:0] data.
package network_tx_pkg;

  localparam int WORD_W         = 134;
  localparam int IFG_CYCLES_DEF = 12;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam logic [7:0] PRE_SFD       = 8'd6;
  localparam logic [7:0] PRE_END       = 8'd7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRE     = 3'd1,
    ST_DATA    = 3'd2,
    ST_IFG     = 3'd3,
    ST_DISCARD = 3'd4
  } tx_state_e;

  typedef enum logic [1:0] {
    FLG_MID  = 2'b00,
    FLG_HEAD = 2'b01,
    FLG_TAIL = 2'b10,
    FLG_BOTH = 2'b11
  } pkt_flag_e;

  function automatic logic is_head(
    input logic [WORD_W-1:0] w
  );
    pkt_flag_e f;
    f = pkt_flag_e'(w[133:132]);
    return (f == FLG_HEAD) || (f == FLG_BOTH);
  endfunction

  function automatic logic is_tail(
    input logic [WORD_W-1:0] w
  );
    pkt_flag_e f;
    f = pkt_flag_e'(w[133:132]);
    return (f == FLG_TAIL) || (f == FLG_BOTH);
  endfunction

endpackage

// File: rtl/network_transmit_serializer_gmii_byte_shifter.sv
// 128-bit word shifter: top byte is the byte currently on txd,
// byte index and last-valid-byte detection for tail words.
module gmii_byte_shifter
  import network_tx_pkg::*;
(
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] word,
  input  logic              advance,
  output logic [7:0]        cur_byte,
  output logic [7:0]        nxt_byte,
  output logic              last_byte,
  output logic              tail
);

  logic [127:0] sr;
  logic [3:0]   idx;
  logic [3:0]   last_idx;
  logic         tail_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sr       <= '0;
      idx      <= '0;
      last_idx <= 4'd15;
      tail_q   <= 1'b0;
    end else if (load) begin
      sr       <= word[127:0];
      idx      <= '0;
      last_idx <= is_tail(word) ? 4'd15 - word[131:128] : 4'd15;
      tail_q   <= is_tail(word);
    end else if (advance) begin
      sr  <= {sr[119:0], 8'h00};
      idx <= idx + 4'd1;
    end
  end

  assign cur_byte  = sr[127:120];
  assign nxt_byte  = sr[119:112];
  assign last_byte = (idx == last_idx);
  assign tail      = tail_q;

endmodule

// File: rtl/network_transmit_serializer.sv
// Packet-word to GMII serializer: preamble/SFD, byte streaming,
// underflow abort, discard of orphan words and inter-frame gap.
module network_transmit_serializer
  import network_tx_pkg::*;
#(
  parameter int IFG_CYCLES = IFG_CYCLES_DEF
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              i_pkt_wr,
  input  logic [WORD_W-1:0] iv_pkt,
  output logic              o_pkt_ready,
  output logic              o_gmii_tx_en,
  output logic [7:0]        ov_gmii_txd,
  output logic              o_gmii_tx_er,
  output logic              o_outpkt_pulse,
  output logic              o_discard_pkt_pulse,
  output logic              o_fifo_underflow_pulse,
  output logic [2:0]        ov_tx_state
);

  localparam logic [7:0] IFG_LAST = 8'(IFG_CYCLES - 1);

  tx_state_e         state, state_n;
  logic [7:0]        cnt, cnt_n;
  logic              hold_valid;
  logic [WORD_W-1:0] hold_word;
  logic              hold_head, hold_tail;
  logic              pop, sh_load, sh_adv;
  logic              tx_en_n, tx_er_n;
  logic [7:0]        txd_n;
  logic              out_n, disc_n, unf_n;
  logic [7:0]        cur_byte, nxt_byte;
  logic              last_byte, sh_tail;

  assign hold_head   = is_head(hold_word);
  assign hold_tail   = is_tail(hold_word);
  assign o_pkt_ready = ~hold_valid;
  assign ov_tx_state = state;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      hold_valid <= 1'b0;
      hold_word  <= '0;
    end else if (i_pkt_wr && !hold_valid) begin
      hold_valid <= 1'b1;
      hold_word  <= iv_pkt;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end

  gmii_byte_shifter u_shifter (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .load      (sh_load),
    .word      (hold_word),
    .advance   (sh_adv),
    .cur_byte  (cur_byte),
    .nxt_byte  (nxt_byte),
    .last_byte (last_byte),
    .tail      (sh_tail)
  );

  // Decides what the registered outputs show in the next cycle.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pop     = 1'b0;
    sh_load = 1'b0;
    sh_adv  = 1'b0;
    tx_en_n = 1'b0;
    tx_er_n = 1'b0;
    txd_n   = 8'h00;
    out_n   = 1'b0;
    disc_n  = 1'b0;
    unf_n   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (hold_valid) begin
          pop = 1'b1;
          if (hold_head) begin
            sh_load = 1'b1;
            state_n = ST_PRE;
            cnt_n   = '0;
            tx_en_n = 1'b1;
            txd_n   = PREAMBLE_BYTE;
          end else begin
            disc_n = 1'b1;
          end
        end
      end
      ST_PRE: begin
        tx_en_n = 1'b1;
        cnt_n   = cnt + 8'd1;
        if (cnt < PRE_SFD) begin
          txd_n = PREAMBLE_BYTE;
        end else if (cnt == PRE_SFD) begin
          txd_n = SFD_BYTE;
        end else begin
          state_n = ST_DATA;
          cnt_n   = '0;
          txd_n   = cur_byte;
        end
      end
      ST_DATA: begin
        if (!last_byte) begin
          sh_adv  = 1'b1;
          tx_en_n = 1'b1;
          txd_n   = nxt_byte;
        end else if (sh_tail) begin
          out_n   = 1'b1;
          state_n = ST_IFG;
          cnt_n   = '0;
        end else if (hold_valid && !hold_head) begin
          pop     = 1'b1;
          sh_load = 1'b1;
          tx_en_n = 1'b1;
          txd_n   = hold_word[127:120];
        end else begin
          tx_en_n = 1'b1;
          tx_er_n = 1'b1;
          unf_n   = 1'b1;
          state_n = ST_DISCARD;
        end
      end
      ST_IFG: begin
        cnt_n = cnt + 8'd1;
        if (cnt == IFG_LAST) begin
          cnt_n = '0;
          // A head held during the gap starts its preamble with no idle slot.
          if (hold_valid && hold_head) begin
            pop     = 1'b1;
            sh_load = 1'b1;
            state_n = ST_PRE;
            tx_en_n = 1'b1;
            txd_n   = PREAMBLE_BYTE;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      ST_DISCARD: begin
        if (hold_valid) begin
          pop = 1'b1;
          if (hold_tail) begin
            state_n = ST_IFG;
            cnt_n   = '0;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state                  <= ST_IDLE;
      cnt                    <= '0;
      o_gmii_tx_en           <= 1'b0;
      o_gmii_tx_er           <= 1'b0;
      ov_gmii_txd            <= 8'h00;
      o_outpkt_pulse         <= 1'b0;
      o_discard_pkt_pulse    <= 1'b0;
      o_fifo_underflow_pulse <= 1'b0;
    end else begin
      state                  <= state_n;
      cnt                    <= cnt_n;
      o_gmii_tx_en           <= tx_en_n;
      o_gmii_tx_er           <= tx_er_n;
      ov_gmii_txd            <= txd_n;
      o_outpkt_pulse         <= out_n;
      o_discard_pkt_pulse    <= disc_n;
      o_fifo_underflow_pulse <= unf_n;
    end
  end

endmodule

// File: tb/tb_network_transmit_serializer.sv
// Directed bench for the GMII transmit serializer.
// Observes every cycle #1 after the rising edge.
module tb_network_transmit_serializer;

  logic         clk_sys;
  logic         reset;
  logic         i_pkt_wr;
  logic [133:0] iv_pkt;
  logic         o_pkt_ready;
  logic         o_gmii_tx_en;
  logic [7:0]   ov_gmii_txd;
  logic         o_gmii_tx_er;
  logic         o_outpkt_pulse;
  logic         o_discard_pkt_pulse;
  logic         o_fifo_underflow_pulse;
  logic [2:0]   ov_tx_state;

  network_transmit_serializer dut (
    .clk_sys                (clk_sys),
    .reset                  (reset),
    .i_pkt_wr               (i_pkt_wr),
    .iv_pkt                 (iv_pkt),
    .o_pkt_ready            (o_pkt_ready),
    .o_gmii_tx_en           (o_gmii_tx_en),
    .ov_gmii_txd            (ov_gmii_txd),
    .o_gmii_tx_er           (o_gmii_tx_er),
    .o_outpkt_pulse         (o_outpkt_pulse),
    .o_discard_pkt_pulse    (o_discard_pkt_pulse),
    .o_fifo_underflow_pulse (o_fifo_underflow_pulse),
    .ov_tx_state            (ov_tx_state)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  int tests, fails, cyc;
  int en_cnt, er_cnt, out_cnt, disc_cnt, unf_cnt, ifg_cnt;
  int ncap, idle_run, last_gap, first_en, head_acc;
  logic prev_en;
  logic [7:0] er_txd;
  logic [7:0] cap [0:255];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
    cyc++;
    if (o_gmii_tx_en) begin
      en_cnt++;
      if (!prev_en) begin
        last_gap = idle_run;
        first_en = cyc;
      end
      idle_run = 0;
      if (o_gmii_tx_er) begin
        er_cnt++;
        er_txd = ov_gmii_txd;
      end else if (ncap < 256) begin
        cap[ncap] = ov_gmii_txd;
        ncap++;
      end
    end else begin
      idle_run++;
    end
    prev_en = o_gmii_tx_en;
    if (o_outpkt_pulse) out_cnt++;
    if (o_discard_pkt_pulse) disc_cnt++;
    if (o_fifo_underflow_pulse) unf_cnt++;
    if (ov_tx_state == 3'd3) ifg_cnt++;
  endtask

  task automatic clr();
    en_cnt = 0; er_cnt = 0; out_cnt = 0; disc_cnt = 0;
    unf_cnt = 0; ifg_cnt = 0; ncap = 0; er_txd = 8'hxx;
    first_en = -1; prev_en = o_gmii_tx_en;
  endtask

  function automatic logic [133:0] mk_word(input logic [1:0] flg,
                                           input logic [3:0] inv,
                                           input logic [7:0] base);
    logic [133:0] w;
    w[133:132] = flg;
    w[131:128] = inv;
    for (int i = 0; i < 16; i++) w[127-8*i -: 8] = base + 8'(i);
    return w;
  endfunction

  task automatic send_word(input logic [133:0] w);
    int g;
    iv_pkt = w;
    i_pkt_wr = 1'b1;
    g = 0;
    while (!o_pkt_ready && g < 100) begin
      step();
      g++;
    end
    check("ready_wait", 32'(g < 100), 1);
    step();
    i_pkt_wr = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] base, input int nw,
                            input logic [3:0] inv);
    logic [1:0] flg;
    for (int k = 0; k < nw; k++) begin
      flg = (k == 0) ? 2'b01 : (k == nw - 1) ? 2'b10 : 2'b00;
      send_word(mk_word(flg, (k == nw - 1) ? inv : 4'd0,
                        base + 8'(16 * k)));
      if (k == 0) head_acc = cyc;
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (ov_tx_state != 3'd0 && g < 300) begin
      step();
      g++;
    end
    check("idle_wait", 32'(g < 300), 1);
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0; idle_run = 0; last_gap = -1;
    reset = 1'b1; i_pkt_wr = 1'b0; iv_pkt = '0;
    repeat (3) @(posedge clk_sys);
    #1;
    check("rst_tx_en", 32'(o_gmii_tx_en), 0);
    check("rst_tx_er", 32'(o_gmii_tx_er), 0);
    check("rst_txd", 32'(ov_gmii_txd), 0);
    check("rst_ready", 32'(o_pkt_ready), 1);
    check("rst_state", 32'(ov_tx_state), 0);
    check("rst_pulses", 32'({o_outpkt_pulse, o_discard_pkt_pulse,
                              o_fifo_underflow_pulse}), 0);
    reset = 1'b0;
    repeat (2) step();

    // 64-byte frame
    clr();
    send_frame(8'h00, 4, 4'd0);
    wait_idle();
    check("f64_latency", 32'(first_en - head_acc), 1);
    check("f64_en", en_cnt, 72);
    check("f64_out", out_cnt, 1);
    check("f64_er", er_cnt, 0);
    check("f64_ifg", ifg_cnt, 12);
    check("f64_pre0", 32'(cap[0]), 32'h55);
    check("f64_pre6", 32'(cap[6]), 32'h55);
    check("f64_sfd", 32'(cap[7]), 32'hD5);
    for (int n = 0; n < 64; n++)
      check($sformatf("f64_byte%0d", n), 32'(cap[8+n]), n);

    // 65-byte frame, tail carries one valid byte
    clr();
    send_frame(8'h40, 5, 4'd15);
    wait_idle();
    check("f65_en", en_cnt, 73);
    check("f65_ncap", ncap, 73);
    check("f65_first", 32'(cap[8]), 32'h40);
    check("f65_last", 32'(cap[72]), 32'h80);
    check("f65_out", out_cnt, 1);

    // two frames back to back
    clr();
    send_frame(8'h10, 4, 4'd0);
    send_frame(8'h90, 4, 4'd0);
    wait_idle();
    check("b2b_gap", last_gap, 12);
    check("b2b_en", en_cnt, 144);
    check("b2b_out", out_cnt, 2);
    check("b2b_sfd2", 32'(cap[79]), 32'hD5);
    check("b2b_b2first", 32'(cap[80]), 32'h90);
    check("b2b_a_last", 32'(cap[71]), 32'h4F);

    // underflow: third word late by 20 cycles
    clr();
    send_word(mk_word(2'b01, 4'd0, 8'h20));
    send_word(mk_word(2'b00, 4'd0, 8'h30));
    begin
      int g;
      g = 0;
      while (!o_pkt_ready && g < 100) begin
        step();
        g++;
      end
      check("unf_ready", 32'(g < 100), 1);
    end
    repeat (20) step();
    send_word(mk_word(2'b00, 4'd0, 8'h40));
    send_word(mk_word(2'b10, 4'd0, 8'h50));
    wait_idle();
    check("unf_en", en_cnt, 41);
    check("unf_er", er_cnt, 1);
    check("unf_er_txd", 32'(er_txd), 0);
    check("unf_ncap", ncap, 40);
    check("unf_byte31", 32'(cap[39]), 32'h3F);
    check("unf_pulse", unf_cnt, 1);
    check("unf_out", out_cnt, 0);
    check("unf_ifg", ifg_cnt, 12);

    // head flag arriving as continuation word
    clr();
    send_word(mk_word(2'b01, 4'd0, 8'h60));
    send_word(mk_word(2'b01, 4'd0, 8'h70));
    send_word(mk_word(2'b10, 4'd0, 8'h80));
    wait_idle();
    check("hd2_en", en_cnt, 25);
    check("hd2_unf", unf_cnt, 1);
    check("hd2_out", out_cnt, 0);
    check("hd2_disc", disc_cnt, 0);

    // orphan middle word while idle
    clr();
    send_word(mk_word(2'b00, 4'd0, 8'hA0));
    repeat (5) step();
    check("orph_disc", disc_cnt, 1);
    check("orph_en", en_cnt, 0);
    check("orph_state", 32'(ov_tx_state), 0);

    // reset mid-frame at data byte 10
    clr();
    send_word(mk_word(2'b01, 4'd0, 8'hB0));
    send_word(mk_word(2'b00, 4'd0, 8'hC0));
    begin
      int g;
      g = 0;
      while (ncap < 19 && g < 100) begin
        step();
        g++;
      end
      check("rmid_reach", 32'(g < 100), 1);
    end
    check("rmid_byte10", 32'(cap[18]), 32'hBA);
    reset = 1'b1;
    #1;
    check("rmid_tx_en", 32'(o_gmii_tx_en), 0);
    check("rmid_tx_er", 32'(o_gmii_tx_er), 0);
    check("rmid_state", 32'(ov_tx_state), 0);
    check("rmid_ready", 32'(o_pkt_ready), 1);
    step();
    reset = 1'b0;
    clr();
    repeat (3) step();
    send_word(mk_word(2'b00, 4'd0, 8'hD0));
    repeat (4) step();
    check("rpost_disc", disc_cnt, 1);
    check("rpost_en", en_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
